ntt4_pipe: RTL and testbench
============================

// Module: ntt4_pipe
// PURPOSE
//   Streaming 4-point cyclic NTT/INTT engine over Z_q, selectable per beat.
//   Accepts one 4-coefficient vector per cycle and produces the transformed vector
//   after a fixed 5-stage pipeline. Inverse mode applies the N^-1 scaling in modular
//   arithmetic. Valid/ready on both sides, full backpressure. Building block for larger
//   NTT datapaths and the polynomial-multiply unit.
// PARAMETERS
//   W          17    coefficient width; must satisfy 2^W > 2*Q
//   Q          7681  prime modulus
//   OMEGA      3383  primitive 4th root of unity mod Q (OMEGA^2 == Q-1)
//   OMEGA_INV  4298  OMEGA^-1 mod Q (== Q-OMEGA)
//   N_INV      5761  4^-1 mod Q
// PORTS
//   clk        in   1    clock, rising edge
//   reset      in   1    synchronous, active-high
//   in_valid   in   1    input vector valid
//   in_ready   out  1    engine can accept this cycle
//   in_inv     in   1    0 = forward NTT, 1 = inverse NTT; sampled with the beat
//   in0..in3   in   W    input coefficients x0..x3 (any W-bit value)
//   out_valid  out  1    output vector valid
//   out_ready  in   1    downstream accepts
//   out_inv    out  1    mode of the beat on out*
//   out0..out3 out  W    output coefficients X0..X3, always in [0,Q)
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high. Reset clears all stage valid bits,
//     data regs, out_valid, out_inv, out0..3 to 0. In-flight beats are discarded.
//     in_ready is 1 in the first cycle after reset deasserts.
//   - Transfer: input on in_valid&&in_ready; output on out_valid&&out_ready.
//   - Global stall: adv = !(out_valid && !out_ready); in_ready = adv. When adv=0, every
//     stage holds (data, valid, mode). When adv=1, all stages shift. Bubbles propagate
//     as valid=0. Never drop or duplicate a beat.
//   - Latency 5 cycles from input transfer to out_valid with no stall.
//     Throughput 1 vector/cycle.
//   - Let w = in_inv ? OMEGA_INV : OMEGA, carried with the beat.
//   - S1: capture x_i = in_i mod Q (full reduction).
//   - S2: a = (x0+x2) mod Q; b = (x0-x2) mod Q; c = (x1+x3) mod Q; d = (x1-x3) mod Q.
//   - S3: e = (d*w) mod Q, using a 2W-bit product. a, b, c are forwarded.
//   - S4: X0 = a+c, X1 = b+e, X2 = a-c, X3 = b-e, each mod Q.
//   - S5: if inv, out_i = (X_i*N_INV) mod Q; else out_i = X_i. Registered outputs.
//   - mod_add: s = a+b; if s >= Q then s-Q. mod_sub: a >= b ? a-b : a+Q-b.
//     Operands are always < Q after S1.
//   - Modes may alternate beat to beat. No flush between forward and inverse beats.
//   - Reset asserted mid-stream: beats accepted before the reset edge never appear.
//   - Out regs hold their value while out_valid=0. Out regs are stable while stalled.
// STRUCTURE
//   - Package ntt_pkg: Q, OMEGA, OMEGA_INV, N_INV defaults; mod_add and mod_sub
//     functions; W sanity check.
//   - Sub-module ntt_mod_mul (combinational a*b mod Q, parameters W, Q).
//     Instantiated 4x in S5 and 1x in S3.
//   - Top: 5 stage registers plus valid/mode shift chain. Stall enable shared by all.
// TESTING
//   1. fwd x=[1,0,0,0] -> out=[1,1,1,1], out_valid at cycle +5.
//   2. fwd x=[0,1,0,0] -> [1,3383,7680,4298]. inv [1,1,1,1] -> [1,0,0,0].
//   3. Round trip: random x<Q, fwd then inv -> original x. Include x=[7680,7680,7680,7680].
//   4. Unreduced input: fwd in0=7682 (= 1 mod Q), others 0 -> [1,1,1,1].
//   5. Backpressure: stream 20 mixed-mode beats, out_ready random 50%.
//      All 20 emerge in order, values and out_inv match the model, no dup/drop.
//      in_ready==0 whenever out_valid&&!out_ready.
//   6. Reset mid-stream with 3 beats in flight -> no out_valid for 5 cycles after
//      release, all outs 0; next beat emerges correctly.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants and modular helpers for the 4-point NTT datapath.
// The helpers work on a fixed 32-bit word; callers narrow the result back to W bits.
package ntt_pkg;

    localparam int unsigned Q_DEFAULT         = 7681;
    localparam int unsigned OMEGA_DEFAULT     = 3383;
    localparam int unsigned OMEGA_INV_DEFAULT = 4298;
    localparam int unsigned N_INV_DEFAULT     = 5761;

    typedef logic [31:0] word_t;

    // Both operands must already be below q.
    function automatic word_t mod_add(input word_t a, input word_t b, input word_t q);
        word_t s;
        s = a + b;
        return (s >= q) ? s - q : s;
    endfunction

    function automatic word_t mod_sub(input word_t a, input word_t b, input word_t q);
        return (a >= b) ? a - b : a + q - b;
    endfunction

    // The sum of two reduced operands must fit in W bits before reduction.
    function automatic bit width_ok(input int unsigned w, input int unsigned q);
        return (longint'(1) << w) > (longint'(2) * longint'(q));
    endfunction

endpackage

// File: rtl/ntt_mod_mul.sv
// Combinational modular multiply: y = (a*b) mod Q over a full 2W-bit product.
module ntt_mod_mul #(
    parameter int unsigned W = 17,
    parameter int unsigned Q = 7681
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    logic [2*W-1:0] prod;

    assign prod = (2*W)'(a) * (2*W)'(b);
    assign y    = W'(prod % (2*W)'(Q));

endmodule

// File: rtl/ntt4_pipe.sv
// Streaming 4-point cyclic NTT/INTT over Z_q, one vector per cycle, 5 register stages.
// A single stall enable derived from the output handshake freezes every stage at once.
module ntt4_pipe
    import ntt_pkg::*;
#(
    parameter int unsigned W         = 17,
    parameter int unsigned Q         = Q_DEFAULT,
    parameter int unsigned OMEGA     = OMEGA_DEFAULT,
    parameter int unsigned OMEGA_INV = OMEGA_INV_DEFAULT,
    parameter int unsigned N_INV     = N_INV_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inv,
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [W-1:0] in3,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_inv,
    output logic [W-1:0] out0,
    output logic [W-1:0] out1,
    output logic [W-1:0] out2,
    output logic [W-1:0] out3
);

    if (!width_ok(W, Q)) begin : g_width_check
        $error("ntt4_pipe: W too narrow for modulus Q");
    end

    localparam logic [W-1:0] OMEGA_W     = W'(OMEGA);
    localparam logic [W-1:0] OMEGA_INV_W = W'(OMEGA_INV);
    localparam logic [W-1:0] N_INV_W     = W'(N_INV);

    function automatic logic [W-1:0] add_q(input logic [W-1:0] a, input logic [W-1:0] b);
        return W'(mod_add(word_t'(a), word_t'(b), word_t'(Q)));
    endfunction

    function automatic logic [W-1:0] sub_q(input logic [W-1:0] a, input logic [W-1:0] b);
        return W'(mod_sub(word_t'(a), word_t'(b), word_t'(Q)));
    endfunction

    // Bit k of vld/inv belongs to stage k+1; bit 4 drives the output handshake.
    logic         adv;
    logic [4:0]   vld;
    logic [4:0]   inv;
    logic [W-1:0] in_vec [4];
    logic [W-1:0] s1_x   [4];
    logic [W-1:0] s2_a, s2_b, s2_c, s2_d;
    logic [W-1:0] s3_a, s3_b, s3_c, s3_e;
    logic [W-1:0] s4_x   [4];
    logic [W-1:0] w_sel;
    logic [W-1:0] e_prod;
    logic [W-1:0] scaled [4];

    assign adv       = !(out_valid && !out_ready);
    assign in_ready  = adv;
    assign out_valid = vld[4];
    assign out_inv   = inv[4];

    always_comb begin
        in_vec[0] = in0;
        in_vec[1] = in1;
        in_vec[2] = in2;
        in_vec[3] = in3;
    end

    assign w_sel = inv[1] ? OMEGA_INV_W : OMEGA_W;

    ntt_mod_mul #(.W(W), .Q(Q)) u_mul_twiddle (
        .a (s2_d),
        .b (w_sel),
        .y (e_prod)
    );

    for (genvar g = 0; g < 4; g++) begin : g_scale
        ntt_mod_mul #(.W(W), .Q(Q)) u_mul_scale (
            .a (s4_x[g]),
            .b (N_INV_W),
            .y (scaled[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld  <= '0;
            inv  <= '0;
            s2_a <= '0;
            s2_b <= '0;
            s2_c <= '0;
            s2_d <= '0;
            s3_a <= '0;
            s3_b <= '0;
            s3_c <= '0;
            s3_e <= '0;
            out0 <= '0;
            out1 <= '0;
            out2 <= '0;
            out3 <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                s1_x[i] <= '0;
                s4_x[i] <= '0;
            end
        end else if (adv) begin
            vld <= {vld[3:0], in_valid};
            inv <= {inv[3:0], in_valid & in_inv};

            for (int unsigned i = 0; i < 4; i++) begin
                s1_x[i] <= W'(in_vec[i] % Q);
            end

            s2_a <= add_q(s1_x[0], s1_x[2]);
            s2_b <= sub_q(s1_x[0], s1_x[2]);
            s2_c <= add_q(s1_x[1], s1_x[3]);
            s2_d <= sub_q(s1_x[1], s1_x[3]);

            s3_a <= s2_a;
            s3_b <= s2_b;
            s3_c <= s2_c;
            s3_e <= e_prod;

            s4_x[0] <= add_q(s3_a, s3_c);
            s4_x[1] <= add_q(s3_b, s3_e);
            s4_x[2] <= sub_q(s3_a, s3_c);
            s4_x[3] <= sub_q(s3_b, s3_e);

            // Output registers only load on a real beat so they keep the last result across bubbles.
            if (vld[3]) begin
                out0 <= inv[3] ? scaled[0] : s4_x[0];
                out1 <= inv[3] ? scaled[1] : s4_x[1];
                out2 <= inv[3] ? scaled[2] : s4_x[2];
                out3 <= inv[3] ? scaled[3] : s4_x[3];
            end
        end
    end

endmodule

// File: tb/tb_ntt4_pipe.sv
// Randomised self-checking bench for ntt4_pipe against a direct-sum NTT reference.
module tb_ntt4_pipe;

    localparam int unsigned W         = 17;
    localparam int unsigned Q         = 7681;
    localparam int unsigned OMEGA     = 3383;
    localparam int unsigned OMEGA_INV = 4298;
    localparam int unsigned N_INV     = 5761;

    typedef logic [3:0][W-1:0] vec_t;
    typedef struct {
        vec_t val;
        logic inv;
        int   t;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_inv = 1'b0;
    logic [W-1:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         out_inv;
    logic [W-1:0] out0, out1, out2, out3;

    always #5 clk = ~clk;

    ntt4_pipe #(
        .W(W), .Q(Q), .OMEGA(OMEGA), .OMEGA_INV(OMEGA_INV), .N_INV(N_INV)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .out_valid(out_valid), .out_ready(out_ready), .out_inv(out_inv),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   n_in     = 0;
    int   n_out    = 0;
    bit   lat_chk  = 0;
    bit   bp_chk   = 0;
    bit   prev_stall = 0;
    vec_t prev_out = '0;
    logic prev_inv = 1'b0;
    vec_t last_out = '0;
    exp_t sb[$];

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic longint pw(input longint b, input int e);
        longint r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % Q;
        return r;
    endfunction

    // X_k = sum_j x_j * w^(j*k) mod Q, scaled by 4^-1 for the inverse.
    function automatic vec_t ntt_ref(input vec_t x, input logic inv);
        vec_t   y;
        longint w, s;
        w = inv ? OMEGA_INV : OMEGA;
        for (int k = 0; k < 4; k++) begin
            s = 0;
            for (int j = 0; j < 4; j++)
                s = (s + (longint'(x[j]) % Q) * pw(w, j * k)) % Q;
            if (inv) s = (s * N_INV) % Q;
            y[k] = W'(s);
        end
        return y;
    endfunction

    function automatic vec_t mk(input int unsigned a, input int unsigned b,
                                input int unsigned c, input int unsigned d);
        vec_t v;
        v[0] = W'(a); v[1] = W'(b); v[2] = W'(c); v[3] = W'(d);
        return v;
    endfunction

    function automatic vec_t rand_vec(input int unsigned maxv);
        vec_t v;
        for (int i = 0; i < 4; i++) v[i] = W'($urandom_range(0, maxv));
        return v;
    endfunction

    task automatic step(input logic rst, input logic iv, input logic inv,
                        input vec_t x, input logic ordy);
        bit   stalled;
        vec_t outs;
        exp_t e;
        @(negedge clk);
        reset = rst; in_valid = iv; in_inv = inv; out_ready = ordy;
        {in3, in2, in1, in0} = x;
        #1;
        outs    = {out3, out2, out1, out0};
        stalled = out_valid && !out_ready;
        if (bp_chk) begin
            check("in_ready", in_ready, !stalled);
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_inv", out_inv, prev_inv);
                for (int i = 0; i < 4; i++) check($sformatf("stall_out%0d", i), outs[i], prev_out[i]);
            end else if (!out_valid) begin
                for (int i = 0; i < 4; i++) check($sformatf("idle_out%0d", i), outs[i], prev_out[i]);
            end
        end
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    e = sb.pop_front();
                    for (int i = 0; i < 4; i++) check($sformatf("out%0d", i), outs[i], e.val[i]);
                    check("out_inv", out_inv, e.inv);
                    if (lat_chk) check("latency", cyc - e.t, 5);
                end
                last_out = outs;
            end
            if (in_valid && in_ready) begin
                n_in++;
                sb.push_back('{val: ntt_ref(x, inv), inv: inv, t: cyc});
            end
        end
        prev_stall = stalled;
        prev_out   = outs;
        prev_inv   = out_inv;
        cyc++;
    endtask

    task automatic drain(input int budget, input bit rnd);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            step(0, 0, 0, '0, rnd ? 1'($urandom % 2) : 1'b1);
            n++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic one(input logic inv, input vec_t x, input vec_t want, input string tag);
        step(0, 1, inv, x, 1);
        drain(20, 0);
        for (int i = 0; i < 4; i++) check($sformatf("%s_%0d", tag, i), last_out[i], want[i]);
    endtask

    vec_t x, r;

    initial begin
        repeat (3) step(1, 0, 0, '0, 1);

        step(0, 0, 0, '0, 1);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_inv", out_inv, 0);
        check("rst_out0", out0, 0);
        check("rst_out3", out3, 0);

        lat_chk = 1;
        one(0, mk(1, 0, 0, 0), mk(1, 1, 1, 1), "impulse");
        one(0, mk(0, 1, 0, 0), mk(1, 3383, 7680, 4298), "shift");
        one(1, mk(1, 1, 1, 1), mk(1, 0, 0, 0), "inv_dc");
        one(0, mk(7682, 0, 0, 0), mk(1, 1, 1, 1), "unreduced");
        one(0, mk(131071, 0, 0, 0), mk(131071 % Q, 131071 % Q, 131071 % Q, 131071 % Q), "maxin");

        for (int k = 0; k < 6; k++) begin
            x = (k == 0) ? mk(7680, 7680, 7680, 7680) : rand_vec(Q - 1);
            step(0, 1, 0, x, 1);
            drain(20, 0);
            r = last_out;
            step(0, 1, 1, r, 1);
            drain(20, 0);
            for (int i = 0; i < 4; i++) check($sformatf("roundtrip%0d", i), last_out[i], x[i]);
        end

        // Back-to-back beats with alternating mode.
        for (int k = 0; k < 6; k++) step(0, 1, 1'(k % 2), rand_vec((1 << W) - 1), 1);
        drain(20, 0);

        lat_chk = 0;
        bp_chk  = 1;
        n_in    = 0;
        n_out   = 0;
        for (int k = 0; k < 400 && n_in < 20; k++)
            step(0, 1'($urandom_range(0, 3) != 0), 1'($urandom % 2),
                 rand_vec((1 << W) - 1), 1'($urandom % 2));
        check("bp_sent", n_in, 20);
        drain(200, 1);
        check("bp_received", n_out, 20);
        bp_chk = 0;

        for (int k = 0; k < 3; k++) step(0, 1, 1'(k % 2), rand_vec(Q - 1), 1);
        step(1, 0, 0, '0, 1);
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, '0, 1);
            check("post_rst_valid", out_valid, 0);
            check("post_rst_outs", {out3, out2, out1, out0}, 0);
        end
        one(1, mk(5, 6, 7, 8), ntt_ref(mk(5, 6, 7, 8), 1), "post_rst_beat");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
